// File: rtl/tff_pkg.sv
// Shared types and defaults for the push-button toggle pulse generator that
// feeds the negedge T flip-flop.
package tff_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HELD = 3'd2,
        RPT  = 3'd3,
        REL  = 3'd4
    } tff_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 20;
    localparam int DEF_REPEAT_DELAY    = 100;
    localparam int DEF_REPEAT_PERIOD   = 50;
    localparam int DEF_CNT_W           = 8;

    // One shared timer must be able to reach the largest of the three thresholds.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw push-button and emits single-cycle toggle pulses, with
// optional auto-repeat while the button stays held.
module toggle_pulse_gen
    import tff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    input  logic             rep_en,
    output logic             t_pulse,
    output logic             btn_level,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int TMR_W = timer_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("toggle_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 2");
    end

    logic             btn_s;
    tff_state_e       state;
    logic [TMR_W-1:0] timer;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Thresholds use >= so that a timer left saturated while rep_en was low
    // fires as soon as rep_en returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            t_pulse   <= 1'b0;
            btn_level <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            t_pulse <= 1'b0;
            if (timer != TMR_MAX) timer <= timer + 1'b1;

            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (btn_s) begin
                        state <= ARM;
                        timer <= '0;
                    end
                end
                ARM: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer >= DEB_LAST) begin
                        state     <= HELD;
                        timer     <= '0;
                        btn_level <= 1'b1;
                        t_pulse   <= 1'b1;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= REL;
                        timer <= '0;
                    end else if (rep_en && timer >= DLY_LAST) begin
                        state     <= RPT;
                        timer     <= '0;
                        t_pulse   <= 1'b1;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                RPT: begin
                    if (!btn_s) begin
                        state <= REL;
                        timer <= '0;
                    end else if (rep_en && timer >= PER_LAST) begin
                        timer     <= '0;
                        t_pulse   <= 1'b1;
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end
                REL: begin
                    if (btn_s) begin
                        state <= HELD;
                        timer <= '0;
                    end else if (timer >= DEB_LAST) begin
                        state     <= IDLE;
                        timer     <= '0;
                        btn_level <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed and randomized checks of toggle_pulse_gen against a time-based
// reference model, including a downstream negedge T flip-flop.
module tb_toggle_pulse_gen;

    localparam int D  = 4;
    localparam int R  = 10;
    localparam int P  = 5;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          btn_in;
    logic          rep_en;
    logic          t_pulse;
    logic          btn_level;
    logic [CW-1:0] pulse_cnt;
    logic          tff_q;

    int n_cmp;
    int n_err;

    // Reference model state: a sample delay line plus run lengths and a
    // due time for the next repeat pulse.
    logic   sq[$];
    bit     lvl;
    int     ones_run;
    int     zero_run;
    longint t_now;
    longint due;
    int     exp_cnt;
    bit     exp_pulse;
    bit     exp_tff;
    bit     prev_pulse;
    int     n_obs_pulses;

    toggle_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (R),
        .REPEAT_PERIOD   (P),
        .CNT_W           (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .rep_en    (rep_en),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .pulse_cnt (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) tff_q <= 1'b0;
        else if (t_pulse) tff_q <= ~tff_q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        sq.push_back(1'b0);
        sq.push_back(1'b0);
        lvl      = 1'b0;
        ones_run = 0;
        zero_run = 0;
        due      = 0;
        exp_cnt  = 0;
        exp_tff  = 1'b0;
        prev_pulse = 1'b0;
    endtask

    task automatic model_edge();
        logic s;
        s = sq.pop_front();
        sq.push_back(btn_in);
        t_now++;
        exp_pulse = 1'b0;
        if (!lvl) begin
            if (s) ones_run++;
            else   ones_run = 0;
            if (ones_run == D + 1) begin
                exp_pulse = 1'b1;
                lvl       = 1'b1;
                due       = t_now + R;
                ones_run  = 0;
                zero_run  = 0;
            end
        end else begin
            if (!s) begin
                zero_run++;
                if (zero_run == D + 1) begin
                    lvl      = 1'b0;
                    zero_run = 0;
                    ones_run = 0;
                end
            end else if (zero_run > 0) begin
                zero_run = 0;
                due      = t_now + R;
            end else if (rep_en && t_now >= due) begin
                exp_pulse = 1'b1;
                due       = t_now + P;
            end
        end
        if (exp_pulse) begin
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            exp_tff = !exp_tff;
        end
    endtask

    // Called at negedge+1; drives inputs, checks after the posedge and the
    // downstream flip-flop after the next negedge.
    task automatic tick(input logic b, input logic r);
        btn_in = b;
        rep_en = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("t_pulse", 32'(t_pulse), 32'(exp_pulse));
        chk("btn_level", 32'(btn_level), 32'(lvl));
        chk("pulse_cnt", 32'(pulse_cnt), 32'(exp_cnt));
        chk("no_back_to_back", 32'(t_pulse & prev_pulse), 32'd0);
        prev_pulse = t_pulse;
        if (t_pulse) n_obs_pulses++;
        @(negedge clk);
        #1;
        chk("tff_q", 32'(tff_q), 32'(exp_tff));
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_t_pulse", 32'(t_pulse), 32'd0);
        chk("rst_btn_level", 32'(btn_level), 32'd0);
        chk("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
        chk("rst_tff_q", 32'(tff_q), 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int lat;
        bit lvl_seg;
        n_cmp = 0;
        n_err = 0;
        t_now = 0;
        n_obs_pulses = 0;
        btn_in = 1'b0;
        rep_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        async_reset();

        // Clean press without repeat, with explicit latency measurement.
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b0);
            if (t_pulse && lat < 0) lat = i;
        end
        chk("press_latency", 32'(lat), 32'd6);
        chk("press_level", 32'(btn_level), 32'd1);
        chk("press_cnt", 32'(pulse_cnt), 32'd1);

        // Release bounce: 0,0,1 then steady low.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        chk("release_level", 32'(btn_level), 32'd0);
        chk("release_cnt", 32'(pulse_cnt), 32'd1);

        // Press bounce: toggles every 2 cycles, then steady high.
        n_obs_pulses = 0;
        for (int i = 0; i < 8; i++) tick(((i / 2) % 2) == 0, 1'b0);
        chk("bounce_no_early_pulse", 32'(n_obs_pulses), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        chk("bounce_one_pulse", 32'(n_obs_pulses), 32'd1);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

        // Reset two cycles into ARM, then a full debounce after release.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        async_reset();
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            if (t_pulse && lat < 0) lat = i;
        end
        chk("post_reset_latency", 32'(lat), 32'd6);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);

        // Auto-repeat long enough for nine pulses: counter wraps 7 -> 0 -> 1.
        async_reset();
        for (int i = 0; i < 53; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        chk("repeat_wrap_cnt", 32'(pulse_cnt), 32'd1);

        // Randomized presses, holds and bounces with rep_en changing per segment.
        for (int ep = 0; ep < 12; ep++) begin
            lvl_seg = 1'b1;
            for (int seg = 0; seg < 6; seg++) begin
                int len;
                logic r;
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 30);
                r   = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < len; i++) tick(lvl_seg, r);
                lvl_seg = !lvl_seg;
            end
            for (int i = 0; i < 15; i++) tick(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
